// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode/funct constants, ALU encodings, squash FSM states
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BGT   = 6'h07;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    SQ_RUN = 2'd0,
    SQ_SQ2 = 2'd1,
    SQ_SQ1 = 2'd2
  } sq_state_e;

  typedef struct packed {
    logic    beq;
    logic    bne;
    logic    bgt;
    alu_op_e alu_op;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    illegal;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two async read ports, one write port
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && wa_i != 5'd0) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Writeback lands this edge, so forward it to a reader in the same cycle
  always_comb begin
    rd1_o = regs_q[ra1_i];
    rd2_o = regs_q[ra2_i];
    if (we_i && wa_i == ra1_i) rd1_o = wd_i;
    if (we_i && wa_i == ra2_i) rd2_o = wd_i;
    if (ra1_i == 5'd0) rd1_o = '0;
    if (ra2_i == 5'd0) rd2_o = '0;
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// rtl/instruction_decode_stage.sv - IF/ID latch, decode, squash FSM and ID/EX latch
module instruction_decode_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic [31:0] IR,
  input  logic        bnoWB,
  input  logic        jnoWB,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] FD_PC,
  output logic        jump,
  output logic [27:0] address,
  output logic [31:0] DX_PC,
  output logic [31:0] DX_rs,
  output logic [31:0] DX_rt,
  output logic [31:0] DX_imm,
  output logic [4:0]  DX_rd,
  output logic        beq,
  output logic        bne,
  output logic        bgt,
  output logic [31:0] offset,
  output logic [2:0]  alu_op,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        illegal
);

  logic [31:0] fd_pc_q, fd_ir_q;
  sq_state_e   sq_q;
  logic [31:0] dx_pc_q, dx_rs_q, dx_rt_q, dx_imm_q;
  logic [4:0]  dx_rd_q;
  ctrl_t       ctrl_q, ctrl_d;
  logic [4:0]  rd_d;
  logic [31:0] rs_val, rt_val;
  logic        squash, kill;

  wire [5:0] opcode = fd_ir_q[31:26];
  wire [5:0] funct  = fd_ir_q[5:0];
  wire [4:0] rs_a   = fd_ir_q[25:21];
  wire [4:0] rt_a   = fd_ir_q[20:16];

  reg_file u_rf (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (rs_a),
    .ra2_i (rt_a),
    .rd1_o (rs_val),
    .rd2_o (rt_val),
    .we_i  (wb_en),
    .wa_i  (wb_addr),
    .wd_i  (wb_data)
  );

  // A squash request kills the instruction currently in decode as well
  assign squash  = bnoWB | jnoWB | (sq_q != SQ_RUN);
  assign kill    = squash | ctrl_d.illegal;
  assign jump    = (opcode == OP_J) & ~squash;
  assign address = {fd_ir_q[25:0], 2'b00};

  always_comb begin
    ctrl_d = '0;
    rd_d   = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_d.reg_write = 1'b1;
        rd_d             = fd_ir_q[15:11];
        case (funct)
          FN_ADD:  ctrl_d.alu_op = ALU_ADD;
          FN_SUB:  ctrl_d.alu_op = ALU_SUB;
          FN_AND:  ctrl_d.alu_op = ALU_AND;
          FN_OR:   ctrl_d.alu_op = ALU_OR;
          FN_SLT:  ctrl_d.alu_op = ALU_SLT;
          default: begin
            ctrl_d         = '0;
            ctrl_d.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl_d.reg_write = 1'b1;
        rd_d             = rt_a;
      end
      OP_LW: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.mem_read  = 1'b1;
        rd_d             = rt_a;
      end
      OP_SW:  ctrl_d.mem_write = 1'b1;
      OP_BEQ: begin ctrl_d.beq = 1'b1; ctrl_d.alu_op = ALU_SUB; end
      OP_BNE: begin ctrl_d.bne = 1'b1; ctrl_d.alu_op = ALU_SUB; end
      OP_BGT: begin ctrl_d.bgt = 1'b1; ctrl_d.alu_op = ALU_SUB; end
      OP_J:   ctrl_d = '0;
      default: ctrl_d.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_q <= SQ_RUN;
    end else if (bnoWB) begin
      sq_q <= SQ_SQ2;
    end else if (jnoWB) begin
      sq_q <= SQ_SQ1;
    end else begin
      case (sq_q)
        SQ_SQ2:  sq_q <= SQ_SQ1;
        default: sq_q <= SQ_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fd_pc_q  <= '0;
      fd_ir_q  <= '0;
      dx_pc_q  <= '0;
      dx_rs_q  <= '0;
      dx_rt_q  <= '0;
      dx_imm_q <= '0;
      dx_rd_q  <= '0;
      ctrl_q   <= '0;
    end else begin
      fd_pc_q  <= PC;
      fd_ir_q  <= IR;
      dx_pc_q  <= kill ? '0 : fd_pc_q;
      dx_rs_q  <= kill ? '0 : rs_val;
      dx_rt_q  <= kill ? '0 : rt_val;
      dx_imm_q <= kill ? '0 : sext16(fd_ir_q[15:0]);
      dx_rd_q  <= kill ? '0 : rd_d;
      ctrl_q   <= squash ? '0 : ctrl_d;
    end
  end

  assign FD_PC     = fd_pc_q;
  assign DX_PC     = dx_pc_q;
  assign DX_rs     = dx_rs_q;
  assign DX_rt     = dx_rt_q;
  assign DX_imm    = dx_imm_q;
  assign DX_rd     = dx_rd_q;
  assign offset    = {dx_imm_q[29:0], 2'b00};
  assign beq       = ctrl_q.beq;
  assign bne       = ctrl_q.bne;
  assign bgt       = ctrl_q.bgt;
  assign alu_op    = ctrl_q.alu_op;
  assign reg_write = ctrl_q.reg_write;
  assign mem_read  = ctrl_q.mem_read;
  assign mem_write = ctrl_q.mem_write;
  assign illegal   = ctrl_q.illegal;

endmodule

// File: doc/instruction_decode_stage.md
INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous, active-high reset.
REQ-002 SHALL have ports: PC  in  32  fetch PC; IR  in  32  fetched instruction; bnoWB  in  1  branch-taken squash request; jnoWB  in  1  jump squash request.
REQ-003 SHALL have ports: wb_en  in  1  writeback enable; wb_addr  in  5  writeback register; wb_data  in  32  writeback value.
REQ-004 SHALL have ports: FD_PC  out  32  PC of instruction in decode; jump  out  1  jump request; address  out  28  jump target low bits.
REQ-005 SHALL have ports: DX_PC  out  32; DX_rs  out  32; DX_rt  out  32; DX_imm  out  32; DX_rd  out  5; beq, bne, bgt  out  1 each; offset  out  32; alu_op  out  3; reg_write, mem_read, mem_write  out  1 each; illegal  out  1.

Function
REQ-006 SHALL register PC and IR into FD_PC/FD_IR every cycle; decode acts on FD_IR.
REQ-007 SHALL decode opcodes FD_IR[31:26]: 0x00 R-type, 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x07 bgt, 0x02 j.
REQ-008 SHALL decode R-type funct FD_IR[5:0]: 0x20 add(alu_op 0), 0x22 sub(1), 0x24 and(2), 0x25 or(3), 0x2A slt(4); other funct -> bubble, illegal=1.
REQ-009 SHALL treat unknown opcodes as bubble with illegal=1 for one DX cycle.
REQ-010 SHALL drive jump and address={FD_IR[25:0],2'b00} combinationally when opcode=0x02 and not squashing.
REQ-011 SHALL latch into DX on each clock: DX_PC=FD_PC, rs/rt read values, DX_imm=sign-extended FD_IR[15:0], DX_rd (rd for R-type, rt for addi/lw), control flags.
REQ-012 SHALL drive offset = DX_imm << 2 (combinational from DX_imm), 32-bit, wraps modulo 2^32.
REQ-013 SHALL assert beq/bne/bgt from DX register only, one cycle per branch; branch sets alu_op=1 (sub), reg_write=0.
REQ-014 SHALL read registers rs=FD_IR[25:21], rt=FD_IR[20:16] combinationally; register 0 reads 0 always.
REQ-015 SHALL write wb_data to wb_addr on clock when wb_en=1 and wb_addr!=0; writes to r0 ignored.
REQ-016 SHALL bypass: same-cycle read of register being written returns wb_data.
REQ-017 SHALL implement squash FSM states RUN, SQ2, SQ1: RUN--bnoWB-->SQ2 (current cycle also squashed); RUN--jnoWB-->SQ1 (current cycle squashed); SQ2->SQ1->RUN.
REQ-018 SHALL, in any squashed cycle, latch bubble into DX (all control/branch flags 0, illegal 0) and hold jump=0.
REQ-019 SHALL give bnoWB priority when bnoWB and jnoWB assert together; a bnoWB during SQ1 restarts at SQ2.
REQ-020 SHALL NOT stall; fetch has no stall input, load-use spacing is the compiler's job.

Reset
REQ-021 SHALL on rst clear FD_PC, FD_IR, all DX outputs, control flags, illegal to 0 and FSM to RUN, asynchronously.
REQ-022 SHALL clear all 32 registers to 0 on rst; rst mid-squash returns to RUN.

Structure
REQ-023 SHALL place opcode/funct constants, alu_op encodings and FSM state encoding in shared package cpu_pkg.
REQ-024 SHALL implement the register file as sub-module reg_file (2 read, 1 write, bypass, r0 zero).

Verification
REQ-025 addi r1,r0,5 (0x20010005) then wb_en, r1=5 -> DX_imm=5, DX_rd=1, reg_write=1; later read of r1 gives 5.
REQ-026 beq with imm=0xFFFF -> DX_imm=0xFFFFFFFF, offset=0xFFFFFFFC, beq=1 for exactly one cycle.
REQ-027 j 0x0000010 in FD -> jump=1, address=0x0000040; jnoWB next cycle -> DX bubble that cycle and the following one.
REQ-028 bnoWB pulse -> three consecutive DX bubbles (current, SQ2, SQ1), then normal decode resumes.
REQ-029 wb_en=1, wb_addr=3, wb_data=0xDEADBEEF while FD reads rs=3 -> DX_rs=0xDEADBEEF; write to r0 -> r0 still 0.
REQ-030 opcode 0x3F -> illegal=1, all control 0 for one cycle; rst asserted mid-SQ2 -> outputs 0, FSM RUN.
